// File: rtl/pulse_shaper_pkg.sv
// Shared types and helpers for the pulse shaper: state encoding and
// parameter legality check.
package pulse_shaper_pkg;

  // 2'b11 is deliberately unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

  function automatic bit count_legal(input int unsigned cycles, input int unsigned width);
    longint max_val;
    max_val = (longint'(1) << width) - 1;
    return (cycles >= 1) && (longint'(cycles) <= max_val);
  endfunction

endpackage

// File: rtl/pulse_shaper_if.sv
// Trigger/pulse signal bundle between control logic (master) and the shaper (slave).
interface pulse_shaper_if;
  logic trig;
  logic z;
  logic busy;
  logic done;
  logic dropped;

  modport master (output trig, input z, input busy, input done, input dropped);
  modport slave  (input trig, output z, output busy, output done, output dropped);
endinterface

// File: rtl/pulse_shaper_cycle_counter.sv
// Loadable down-counter that saturates at zero; the owner decides when to reload.
module cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; the zero guard keeps cnt from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_shaper.sv
// Turns single-cycle trigger strobes into fixed-width high pulses separated by
// a minimum low gap, queueing one trigger while busy and flagging the rest.
module pulse_shaper #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  pulse_shaper_if.slave bus
);
  import pulse_shaper_pkg::*;

`ifndef SYNTHESIS
  if (!count_legal(HIGH_CYCLES, CNT_W)) begin : g_bad_high
    $error("pulse_shaper: HIGH_CYCLES=%0d out of range for CNT_W=%0d", HIGH_CYCLES, CNT_W);
  end
  if (!count_legal(GAP_CYCLES, CNT_W)) begin : g_bad_gap
    $error("pulse_shaper: GAP_CYCLES=%0d out of range for CNT_W=%0d", GAP_CYCLES, CNT_W);
  end
`endif

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             pending;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             en;
  logic             zero;
  logic             queue_req;

  cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .zero     (zero)
  );

  // A trigger on the last gap cycle starts the next pulse directly, so only
  // triggers arriving earlier in the busy window go through the pending slot.
  assign queue_req = bus.trig && ((state == HIGH) || ((state == GAP) && !zero));

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    en         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.trig) begin
          next_state = HIGH;
          load       = 1'b1;
          load_val   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (zero) begin
          next_state = GAP;
          load       = 1'b1;
          load_val   = GAP_LOAD;
        end else begin
          en = 1'b1;
        end
      end
      GAP: begin
        if (zero) begin
          if (pending || bus.trig) begin
            next_state = HIGH;
            load       = 1'b1;
            load_val   = HIGH_LOAD;
          end else begin
            next_state = IDLE;
          end
        end else begin
          en = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // z and busy are registered from next_state so they line up with state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      bus.z       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.dropped <= 1'b0;
    end else begin
      state       <= next_state;
      bus.z       <= (next_state == HIGH);
      bus.busy    <= (next_state != IDLE);
      bus.done    <= 1'b0;
      bus.dropped <= 1'b0;
      if (queue_req) begin
        if (pending) begin
          bus.dropped <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end else if ((state == GAP) && zero) begin
        bus.done    <= 1'b1;
        pending     <= 1'b0;
        bus.dropped <= pending && bus.trig;
      end else if ((state != HIGH) && (state != GAP)) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_shaper.sv
// Scoreboard bench for pulse_shaper: directed trigger vectors push expected
// per-cycle {z,busy,done,dropped}; monitors pop and compare on the falling edge.
module tb_pulse_shaper;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb0[$];
  exp_t sb1[$];

  pulse_shaper_if bus0();
  pulse_shaper_if bus1();

  pulse_shaper #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pulse_shaper #(.HIGH_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s {z,busy,done,dropped} actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic pushExp(input int dut, input string name, input int cyc, input logic [3:0] val);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.val  = val;
    if (dut == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  // Bit i of each vector is the value for cycle i, cycle 0 being the first driven cycle.
  task automatic applyStimulus(input int dut, input string name, input int n,
                               input logic [31:0] trigv, input logic [31:0] zv,
                               input logic [31:0] busyv, input logic [31:0] donev,
                               input logic [31:0] dropv);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (dut == 0) bus0.trig = trigv[i];
      else          bus1.trig = trigv[i];
      pushExp(dut, name, i, {zv[i], busyv[i], donev[i], dropv[i]});
    end
    @(posedge clk);
    #1;
    bus0.trig = 1'b0;
    bus1.trig = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      checkOutput($sformatf("%s c%0d", e.name, e.cyc),
                  {bus0.z, bus0.busy, bus0.done, bus0.dropped}, e.val);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      checkOutput($sformatf("%s c%0d", e.name, e.cyc),
                  {bus1.z, bus1.busy, bus1.done, bus1.dropped}, e.val);
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus0.trig = 1'b0;
    bus1.trig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dut0", {bus0.z, bus0.busy, bus0.done, bus0.dropped}, 4'b0000);
    checkOutput("reset dut1", {bus1.z, bus1.busy, bus1.done, bus1.dropped}, 4'b0000);
    rst = 1'b0;

    $display("[TB] default parameter scenarios");
    applyStimulus(0, "single",   10, 32'h1,  32'h1E,  32'h7E,   32'h80,   32'h0);
    applyStimulus(0, "queued",   16, 32'h5,  32'h79E, 32'h1FFE, 32'h2080, 32'h0);
    applyStimulus(0, "overflow", 16, 32'hD,  32'h79E, 32'h1FFE, 32'h2080, 32'h10);
    applyStimulus(0, "lastgap",  16, 32'h41, 32'h79E, 32'h1FFE, 32'h2080, 32'h0);
    applyStimulus(0, "lastgap_pending", 16, 32'h45, 32'h79E, 32'h1FFE, 32'h2080, 32'h80);

    $display("[TB] asynchronous reset mid-pulse");
    @(posedge clk); #1; bus0.trig = 1'b1; pushExp(0, "rst", 0, 4'b0000);
    @(posedge clk); #1; bus0.trig = 1'b1; pushExp(0, "rst", 1, 4'b1100);
    @(posedge clk); #1; bus0.trig = 1'b0; pushExp(0, "rst", 2, 4'b0000);
    #1 rst = 1'b1;
    #1 checkOutput("rst_async", {bus0.z, bus0.busy, bus0.done, bus0.dropped}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, "post_rst",   12, 32'h0, 32'h0,  32'h0,  32'h0,  32'h0);
    applyStimulus(0, "rst_single", 14, 32'h1, 32'h1E, 32'h7E, 32'h80, 32'h0);

    $display("[TB] HIGH_CYCLES=1 GAP_CYCLES=1 sustained trigger");
    applyStimulus(1, "sweep", 13, 32'hFF, 32'h2AA, 32'h7FE, 32'hAA8, 32'hA8);

    repeat (2) @(negedge clk);
    checks++;
    if ((sb0.size() + sb1.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain leftover=%0d required=0", sb0.size() + sb1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
